// File: rtl/fetch_stage_pkg.sv
// Shared widths, defaults and the buffered-instruction bundle
// for the instruction-fetch stage.
package fetch_stage_pkg;

    localparam int PC_W    = 32;
    localparam int INSTR_W = 32;

    localparam logic [PC_W-1:0] PC_STEP_DEF  = 32'd4;
    localparam logic [PC_W-1:0] RESET_PC_DEF = 32'h0000_0000;

    typedef struct packed {
        logic [PC_W-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

    localparam int ENTRY_W = $bits(fetch_entry_t);

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with flush; a full FIFO accepts a push when
// it is popped in the same cycle.
module fetch_fifo
    import fetch_stage_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int DW    = ENTRY_W,
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          flush,
    input  logic          push,
    input  logic [DW-1:0] push_data,
    input  logic          pop,
    output logic [DW-1:0] head,
    output logic          empty,
    output logic          full,
    output logic [CW-1:0] count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

    logic [DW-1:0] mem [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] cnt;
    logic          do_push;
    logic          do_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PW'(1);
    endfunction

    assign empty   = (cnt == '0);
    assign full    = (cnt == FULL_CNT);
    assign count   = cnt;
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clock) begin
        if (!reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= ptr_inc(wr_ptr);
            if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
            cnt <= cnt + CW'(do_push) - CW'(do_pop);
        end
    end

    // Storage carries no reset; only the pointers define validity.
    always_ff @(posedge clock) begin
        if (reset && !flush && do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: next-PC selection, credit-limited memory
// requests, stale-response dropping and the decode buffer.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC   = RESET_PC_DEF,
    parameter int              FIFO_DEPTH = 2,
    parameter logic [PC_W-1:0] PC_STEP    = PC_STEP_DEF
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [PC_W-1:0]    pc_q,
    output logic [PC_W-1:0]    pc_d,
    input  logic               redirect_valid,
    input  logic [PC_W-1:0]    redirect_target,
    output logic               imem_req_valid,
    input  logic               imem_req_ready,
    output logic [PC_W-1:0]    imem_req_addr,
    input  logic               imem_resp_valid,
    input  logic [INSTR_W-1:0] imem_resp_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [PC_W-1:0]    out_pc,
    output logic [INSTR_W-1:0] out_instr
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [CW:0] CREDIT_MAX = (CW + 1)'(FIFO_DEPTH);

    logic [CW-1:0] outstanding;
    logic [CW-1:0] drop_cnt;
    logic [CW-1:0] out_count;
    logic [CW:0]   credit_sum;
    logic          credit_ok;
    logic          req_fire;
    logic          resp_fire;
    logic          discard;
    logic          out_push;
    logic          out_pop;
    logic          out_full;
    logic          out_empty;
    fetch_entry_t  out_entry;
    fetch_entry_t  out_head;
    logic [PC_W-1:0] inflight_pc;
    logic            inflight_empty;
    logic            unused_inflight_full;
    logic [CW-1:0]   unused_inflight_count;

    assign credit_sum = {1'b0, outstanding} + {1'b0, out_count};
    assign credit_ok  = credit_sum < CREDIT_MAX;

    assign imem_req_valid = reset && credit_ok && !redirect_valid;
    assign imem_req_addr  = pc_q;
    assign req_fire       = imem_req_valid && imem_req_ready;

    // A beat with nothing recorded in flight cannot be ours.
    assign resp_fire = reset && imem_resp_valid && !inflight_empty;
    assign discard   = (drop_cnt != '0) || redirect_valid;
    assign out_push  = resp_fire && !discard;
    assign out_pop   = out_valid && out_ready;

    assign out_entry.pc    = inflight_pc;
    assign out_entry.instr = imem_resp_data;

    always_comb begin
        pc_d = pc_q;
        if (!reset) begin
            pc_d = RESET_PC;
        end else if (redirect_valid) begin
            pc_d = redirect_target;
        end else if (req_fire) begin
            pc_d = pc_q + PC_STEP;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            outstanding <= '0;
            drop_cnt    <= '0;
        end else begin
            outstanding <= outstanding + CW'(req_fire) - CW'(resp_fire);
            // Everything still in flight after this cycle is stale.
            if (redirect_valid) begin
                drop_cnt <= outstanding - CW'(resp_fire);
            end else if (resp_fire && drop_cnt != '0) begin
                drop_cnt <= drop_cnt - CW'(1);
            end
        end
    end

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .DW    (ENTRY_W)
    ) u_out_fifo (
        .clock     (clock),
        .reset     (reset),
        .flush     (redirect_valid),
        .push      (out_push),
        .push_data (out_entry),
        .pop       (out_pop),
        .head      (out_head),
        .empty     (out_empty),
        .full      (out_full),
        .count     (out_count)
    );

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .DW    (PC_W)
    ) u_inflight (
        .clock     (clock),
        .reset     (reset),
        .flush     (1'b0),
        .push      (req_fire),
        .push_data (pc_q),
        .pop       (resp_fire),
        .head      (inflight_pc),
        .empty     (inflight_empty),
        .full      (unused_inflight_full),
        .count     (unused_inflight_count)
    );

    assign out_valid = !out_empty;
    assign out_pc    = out_head.pc;
    assign out_instr = out_head.instr;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a PC latch and a
// fixed-latency memory model.
module tb_fetch_stage;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] pc_q;
    logic [31:0] pc_d;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_target = 32'h0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b1;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_pc;
    logic [31:0] out_instr;

    int checks = 0;
    int failures = 0;
    int mem_lat = 1;

    logic        sr_v [8];
    logic [31:0] sr_a [8];

    fetch_stage dut (
        .clock           (clock),
        .reset           (reset),
        .pc_q            (pc_q),
        .pc_d            (pc_d),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_pc          (out_pc),
        .out_instr       (out_instr)
    );

    always #5 clock = ~clock;

    always @(posedge clock) pc_q <= pc_d;

    // Memory image: word at addr is {16'hC0DE, addr[15:0]}.
    always @(posedge clock) begin
        if (!reset) begin
            for (int i = 0; i < 8; i++) sr_v[i] <= 1'b0;
        end else begin
            for (int i = 0; i < 7; i++) begin
                sr_v[i] <= sr_v[i+1];
                sr_a[i] <= sr_a[i+1];
            end
            sr_v[7] <= 1'b0;
            if (imem_req_valid && imem_req_ready) begin
                sr_v[mem_lat-1] <= 1'b1;
                sr_a[mem_lat-1] <= imem_req_addr;
            end
        end
    end

    assign imem_resp_valid = sr_v[0];
    assign imem_resp_data  = {16'hC0DE, sr_a[0][15:0]};

    always @(posedge clock) begin
        if (reset && dut.out_push && dut.out_full && !dut.out_pop) begin
            $display("FAIL fifo_overflow at %0t", $time);
            failures++;
        end
    end

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b0;
        redirect_valid = 1'b0;
        repeat (2) @(negedge clock);
    endtask

    task automatic do_release();
        @(negedge clock);
        reset = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        mem_lat = 1;
        out_ready = 1'b1;
        do_reset();
        checks++; if (pc_d !== 32'h0) begin $display("FAIL rst_pc_d got=%h exp=0", pc_d); failures++; end
        checks++; if (imem_req_valid !== 1'b0) begin $display("FAIL rst_req got=%b exp=0", imem_req_valid); failures++; end
        checks++; if (out_valid !== 1'b0) begin $display("FAIL rst_out_valid got=%b exp=0", out_valid); failures++; end
    endtask

    task automatic test_stream();
        logic [31:0] e_pcd [7];
        logic        e_req [7];
        logic        e_ov  [7];
        logic [31:0] e_opc [7];
        e_pcd = '{32'd4, 32'd8, 32'd8, 32'd12, 32'd16, 32'd16, 32'd20};
        e_req = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        e_ov  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        e_opc = '{32'd0, 32'd0, 32'd0, 32'd4, 32'd0, 32'd8, 32'd12};
        mem_lat = 1;
        out_ready = 1'b1;
        do_reset();
        do_release();
        for (int c = 0; c < 7; c++) begin
            if (c > 0) @(negedge clock);
            checks++; if (pc_d !== e_pcd[c]) begin $display("FAIL stream_pc_d c%0d got=%h exp=%h", c, pc_d, e_pcd[c]); failures++; end
            checks++; if (imem_req_valid !== e_req[c]) begin $display("FAIL stream_req c%0d got=%b exp=%b", c, imem_req_valid, e_req[c]); failures++; end
            checks++; if (out_valid !== e_ov[c]) begin $display("FAIL stream_ov c%0d got=%b exp=%b", c, out_valid, e_ov[c]); failures++; end
            if (e_ov[c]) begin
                checks++; if (out_pc !== e_opc[c]) begin $display("FAIL stream_pc c%0d got=%h exp=%h", c, out_pc, e_opc[c]); failures++; end
                checks++; if (out_instr !== {16'hC0DE, e_opc[c][15:0]}) begin $display("FAIL stream_instr c%0d got=%h", c, out_instr); failures++; end
            end
        end
    endtask

    task automatic test_stall();
        mem_lat = 1;
        out_ready = 1'b0;
        do_reset();
        do_release();
        @(negedge clock);
        for (int c = 2; c < 12; c++) begin
            @(negedge clock);
            checks++; if (imem_req_valid !== 1'b0) begin $display("FAIL stall_req c%0d got=%b exp=0", c, imem_req_valid); failures++; end
            checks++; if (pc_d !== 32'd8) begin $display("FAIL stall_pc_d c%0d got=%h exp=8", c, pc_d); failures++; end
            checks++; if (out_pc !== 32'd0) begin $display("FAIL stall_head c%0d got=%h exp=0", c, out_pc); failures++; end
        end
        out_ready = 1'b1;
        #1;
        checks++; if (!(out_valid === 1'b1 && out_pc === 32'd0)) begin $display("FAIL stall_rel0 got=%b/%h exp=1/0", out_valid, out_pc); failures++; end
        @(negedge clock);
        checks++; if (!(out_valid === 1'b1 && out_pc === 32'd4)) begin $display("FAIL stall_rel4 got=%b/%h exp=1/4", out_valid, out_pc); failures++; end
    endtask

    task automatic test_redirect();
        mem_lat = 3;
        out_ready = 1'b1;
        do_reset();
        do_release();
        @(negedge clock);
        @(negedge clock);
        redirect_valid = 1'b1;
        redirect_target = 32'h100;
        #1;
        checks++; if (imem_req_valid !== 1'b0) begin $display("FAIL redir_req got=%b exp=0", imem_req_valid); failures++; end
        checks++; if (pc_d !== 32'h100) begin $display("FAIL redir_pc_d got=%h exp=100", pc_d); failures++; end
        @(negedge clock);
        redirect_valid = 1'b0;
        #1;
        checks++; if (dut.drop_cnt !== 2'd2) begin $display("FAIL redir_drop got=%0d exp=2", dut.drop_cnt); failures++; end
        for (int c = 3; c < 8; c++) begin
            if (c > 3) @(negedge clock);
            checks++; if (out_valid !== 1'b0) begin $display("FAIL redir_stale c%0d got=%b exp=0", c, out_valid); failures++; end
        end
        @(negedge clock);
        checks++; if (!(out_valid === 1'b1 && out_pc === 32'h100)) begin $display("FAIL redir_new got=%b/%h exp=1/100", out_valid, out_pc); failures++; end
        checks++; if (out_instr !== 32'hC0DE_0100) begin $display("FAIL redir_instr got=%h exp=c0de0100", out_instr); failures++; end
    endtask

    task automatic test_redirect_resp();
        mem_lat = 1;
        out_ready = 1'b1;
        do_reset();
        do_release();
        @(negedge clock);
        @(negedge clock);
        checks++; if (!(out_valid === 1'b1 && imem_resp_valid === 1'b1)) begin $display("FAIL rr_setup got=%b/%b exp=1/1", out_valid, imem_resp_valid); failures++; end
        redirect_valid = 1'b1;
        redirect_target = 32'h200;
        #1;
        checks++; if (imem_req_valid !== 1'b0) begin $display("FAIL rr_req got=%b exp=0", imem_req_valid); failures++; end
        @(negedge clock);
        redirect_valid = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin $display("FAIL rr_flush got=%b exp=0", out_valid); failures++; end
        checks++; if (dut.drop_cnt !== 2'd0) begin $display("FAIL rr_drop got=%0d exp=0", dut.drop_cnt); failures++; end
        checks++; if (pc_d !== 32'h204) begin $display("FAIL rr_pc_d got=%h exp=204", pc_d); failures++; end
        @(negedge clock);
        @(negedge clock);
        checks++; if (!(out_valid === 1'b1 && out_pc === 32'h200)) begin $display("FAIL rr_new got=%b/%h exp=1/200", out_valid, out_pc); failures++; end
    endtask

    task automatic test_wrap();
        mem_lat = 1;
        out_ready = 1'b1;
        do_reset();
        @(negedge clock);
        reset = 1'b1;
        redirect_valid = 1'b1;
        redirect_target = 32'hFFFF_FFFC;
        #1;
        checks++; if (pc_d !== 32'hFFFF_FFFC) begin $display("FAIL wrap_target got=%h exp=fffffffc", pc_d); failures++; end
        @(negedge clock);
        redirect_valid = 1'b0;
        #1;
        checks++; if (!(imem_req_valid === 1'b1 && pc_d === 32'h0)) begin $display("FAIL wrap_pc_d got=%b/%h exp=1/0", imem_req_valid, pc_d); failures++; end
        @(negedge clock);
        @(negedge clock);
        checks++; if (!(out_valid === 1'b1 && out_pc === 32'hFFFF_FFFC)) begin $display("FAIL wrap_out got=%b/%h exp=1/fffffffc", out_valid, out_pc); failures++; end
        checks++; if (out_instr !== 32'hC0DE_FFFC) begin $display("FAIL wrap_instr got=%h exp=c0defffc", out_instr); failures++; end
    endtask

    task automatic test_reset_mid();
        mem_lat = 1;
        out_ready = 1'b0;
        do_reset();
        do_release();
        repeat (3) @(negedge clock);
        checks++; if (!(out_valid === 1'b1 && dut.out_count === 2'd2)) begin $display("FAIL rm_full got=%b/%0d exp=1/2", out_valid, dut.out_count); failures++; end
        reset = 1'b0;
        #1;
        checks++; if (!(pc_d === 32'h0 && imem_req_valid === 1'b0)) begin $display("FAIL rm_comb got=%h/%b exp=0/0", pc_d, imem_req_valid); failures++; end
        @(negedge clock);
        checks++; if (!(out_valid === 1'b0 && imem_req_valid === 1'b0 && pc_d === 32'h0)) begin $display("FAIL rm_cleared got=%b/%b/%h exp=0/0/0", out_valid, imem_req_valid, pc_d); failures++; end
        out_ready = 1'b1;
        do_release();
        checks++; if (!(imem_req_valid === 1'b1 && pc_d === 32'd4)) begin $display("FAIL rm_restart got=%b/%h exp=1/4", imem_req_valid, pc_d); failures++; end
        @(negedge clock);
        @(negedge clock);
        checks++; if (!(out_valid === 1'b1 && out_pc === 32'd0)) begin $display("FAIL rm_first got=%b/%h exp=1/0", out_valid, out_pc); failures++; end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_redirect();
        test_redirect_resp();
        test_wrap();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
